// File: rtl/cel_unpack.sv
// cel_unpack: turns one cel source row (32-bit words, MSB-first) into raw pixels for pdec.
// Handles unpacked rows and packed rows made of literal, transparent and repeat runs.
// "packed" is a reserved word in SystemVerilog, so the row-format input is named packed_mode.
module cel_unpack #(
    parameter int unsigned BUF_W = 64
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        row_start,
    input  logic [2:0]  bpp_code,
    input  logic        packed_mode,
    input  logic [10:0] row_width,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic [15:0] pix_out,
    output logic        pix_transp,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        row_done,
    output logic        busy
);

    localparam int unsigned FW = $clog2(BUF_W + 1);
    localparam logic [FW-1:0] FillMax = FW'(BUF_W - 32);

    typedef enum logic [3:0] {
        StIdle, StHdr, StPkt, StLit, StTrn, StRepLd, StRep, StUnpk, StFlush, StDone
    } state_e;

    state_e           state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [4:0]       bpp_q, bpp_d;
    logic             packed_q, packed_d;
    logic [10:0]      pix_q, pix_d;     // pixels still to emit in an unpacked row
    logic [10:0]      wcnt_q, wcnt_d;
    logic [10:0]      wlen_q, wlen_d;
    logic [6:0]       run_q, run_d;
    logic [15:0]      rep_q, rep_d;
    logic [15:0]      pix_out_q, pix_out_d;
    logic             pix_transp_q, pix_transp_d;
    logic             pix_valid_q, pix_valid_d;
    logic             row_done_q, row_done_d;
    logic             busy_q, busy_d;

    logic [4:0]       bpp_dec;
    logic [FW-1:0]    bpp_w;
    logic             have_pix, have_hdr, words_left, out_free;
    logic [15:0]      top16, pop_pix;
    logic [7:0]       pop_hdr;
    logic [31:0]      rem_bits;
    logic [4:0]       pop_n;
    logic             accept, push, clear;
    logic [FW-1:0]    fill_pop;
    logic [BUF_W-1:0] buf_pop;

    // Bits-per-pixel decode; zero marks a reserved code.
    always_comb begin
        case (bpp_code)
            3'd1:    bpp_dec = 5'd1;
            3'd2:    bpp_dec = 5'd2;
            3'd3:    bpp_dec = 5'd4;
            3'd4:    bpp_dec = 5'd6;
            3'd5:    bpp_dec = 5'd8;
            3'd6:    bpp_dec = 5'd16;
            default: bpp_dec = 5'd0;
        endcase
    end

    assign bpp_w      = FW'(bpp_q);
    assign have_pix   = fill_q >= bpp_w;
    assign have_hdr   = fill_q >= FW'(8);
    assign words_left = wcnt_q < wlen_q;
    assign out_free   = !pix_valid_q || pix_ready;
    assign top16      = buf_q[BUF_W-1 -: 16];
    assign pop_pix    = top16 >> (5'd16 - bpp_q);
    assign pop_hdr    = buf_q[BUF_W-1 -: 8];
    assign rem_bits   = 32'(pix_q) * 32'(bpp_q);

    // Source ready: only from registered state, never from pix_ready.
    always_comb begin
        word_ready = 1'b0;
        case (state_q)
            StHdr:                              word_ready = 1'b1;
            StPkt, StLit, StTrn, StRepLd, StRep: word_ready = words_left && (fill_q <= FillMax);
            // Unpacked rows stop fetching once the buffer covers the remaining pixels.
            StUnpk:  word_ready = (fill_q <= FillMax) && (32'(fill_q) < rem_bits);
            StFlush: word_ready = packed_q && words_left;
            default: word_ready = 1'b0;
        endcase
    end

    // Row sequencing, bit-buffer pop/push and output register next state.
    always_comb begin
        state_d      = state_q;
        bpp_d        = bpp_q;
        packed_d     = packed_q;
        pix_d        = pix_q;
        wcnt_d       = wcnt_q;
        wlen_d       = wlen_q;
        run_d        = run_q;
        rep_d        = rep_q;
        pix_out_d    = pix_out_q;
        pix_transp_d = pix_transp_q;
        pix_valid_d  = pix_valid_q;
        row_done_d   = 1'b0;
        busy_d       = busy_q;
        pop_n        = 5'd0;
        clear        = 1'b0;

        accept = word_valid && word_ready;
        // The header word is parsed directly and flushed words are dropped.
        push   = accept && (state_q != StHdr) && (state_q != StFlush);

        if (pix_valid_q && pix_ready) pix_valid_d = 1'b0;
        if (accept) wcnt_d = wcnt_q + 11'd1;

        case (state_q)
            StIdle: begin
                if (row_start) begin
                    bpp_d    = bpp_dec;
                    packed_d = packed_mode;
                    pix_d    = row_width;
                    wcnt_d   = 11'd0;
                    wlen_d   = 11'd0;
                    busy_d   = 1'b1;
                    if (bpp_dec == 5'd0)  state_d = StDone;
                    else if (packed_mode) state_d = StHdr;
                    else                  state_d = StUnpk;
                end
            end
            StHdr: begin
                if (accept) begin
                    wlen_d  = 11'(word_in[9:0]) + 11'd2;
                    state_d = StPkt;
                end
            end
            StPkt: begin
                if (have_hdr) begin
                    pop_n = 5'd8;
                    run_d = {1'b0, pop_hdr[5:0]} + 7'd1;
                    case (pop_hdr[7:6])
                        2'b00:   state_d = StFlush;
                        2'b01:   state_d = StLit;
                        2'b10:   state_d = StTrn;
                        default: state_d = StRepLd;
                    endcase
                end else if (!words_left) begin
                    state_d = StFlush;
                end
            end
            StLit: begin
                if (have_pix) begin
                    if (out_free) begin
                        pop_n        = bpp_q;
                        pix_out_d    = pop_pix;
                        pix_transp_d = 1'b0;
                        pix_valid_d  = 1'b1;
                        run_d        = run_q - 7'd1;
                        if (run_q == 7'd1) state_d = StPkt;
                    end
                end else if (!words_left) begin
                    state_d = StFlush;
                end
            end
            StTrn: begin
                if (out_free) begin
                    pix_out_d    = 16'd0;
                    pix_transp_d = 1'b1;
                    pix_valid_d  = 1'b1;
                    run_d        = run_q - 7'd1;
                    if (run_q == 7'd1) state_d = StPkt;
                end
            end
            StRepLd: begin
                if (have_pix) begin
                    pop_n   = bpp_q;
                    rep_d   = pop_pix;
                    state_d = StRep;
                end else if (!words_left) begin
                    state_d = StFlush;
                end
            end
            StRep: begin
                if (out_free) begin
                    pix_out_d    = rep_q;
                    pix_transp_d = 1'b0;
                    pix_valid_d  = 1'b1;
                    run_d        = run_q - 7'd1;
                    if (run_q == 7'd1) state_d = StPkt;
                end
            end
            StUnpk: begin
                if (pix_q == 11'd0) begin
                    clear   = 1'b1;
                    state_d = StDone;
                end else if (have_pix && out_free) begin
                    pop_n        = bpp_q;
                    pix_out_d    = pop_pix;
                    pix_transp_d = 1'b0;
                    pix_valid_d  = 1'b1;
                    pix_d        = pix_q - 11'd1;
                end
            end
            StFlush: begin
                if (!packed_q || !words_left) begin
                    clear   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                // Pulse row_done only after the last pixel has left the output register.
                if (row_done_q) begin
                    state_d = StIdle;
                end else if (!pix_valid_q) begin
                    row_done_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        fill_pop = fill_q - FW'(pop_n);
        buf_pop  = buf_q << pop_n;
        buf_d    = buf_pop;
        fill_d   = fill_pop;
        if (push) begin
            buf_d  = buf_pop | ({word_in, {(BUF_W-32){1'b0}}} >> fill_pop);
            fill_d = fill_pop + FW'(32);
        end
        if (clear) begin
            buf_d  = '0;
            fill_d = '0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= StIdle;
            buf_q        <= '0;
            fill_q       <= '0;
            bpp_q        <= 5'd0;
            packed_q     <= 1'b0;
            pix_q        <= 11'd0;
            wcnt_q       <= 11'd0;
            wlen_q       <= 11'd0;
            run_q        <= 7'd0;
            rep_q        <= 16'd0;
            pix_out_q    <= 16'd0;
            pix_transp_q <= 1'b0;
            pix_valid_q  <= 1'b0;
            row_done_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            fill_q       <= fill_d;
            bpp_q        <= bpp_d;
            packed_q     <= packed_d;
            pix_q        <= pix_d;
            wcnt_q       <= wcnt_d;
            wlen_q       <= wlen_d;
            run_q        <= run_d;
            rep_q        <= rep_d;
            pix_out_q    <= pix_out_d;
            pix_transp_q <= pix_transp_d;
            pix_valid_q  <= pix_valid_d;
            row_done_q   <= row_done_d;
            busy_q       <= busy_d;
        end
    end

    assign pix_out    = pix_out_q;
    assign pix_transp = pix_transp_q;
    assign pix_valid  = pix_valid_q;
    assign row_done   = row_done_q;
    assign busy       = busy_q;

endmodule

// File: doc/cel_unpack.md
# cel_unpack

Cel row unpacker sitting directly upstream of `pdec`. It consumes 32-bit cel source words, extracts raw pixels MSB-first at the cel's bit depth, and expands packed rows (literal, transparent and repeat runs). It emits one zero-extended 16-bit raw pixel per beat, plus a transparency flag, to the `pdec` `pixel_in` path. One instance handles one row per `row_start`.

## Interface

- `BUF_W`, default 64: bit-buffer width; must be ≥ 48.
- `aclk` in 1: clock.
- `areset` in 1: synchronous, active-high reset.
- `row_start` in 1: one-cycle pulse; latches config and starts a row; ignored unless in IDLE.
- `bpp_code` in 3: 1=1, 2=2, 3=4, 4=6, 5=8, 6=16 bits per pixel; 0 and 7 are reserved.
- `packed` in 1: 1 = packed row format.
- `row_width` in 11: pixel count for unpacked rows; 0 means no pixels.
- `word_in` in 32: cel source word.
- `word_valid` in 1: source handshake valid.
- `word_ready` out 1: source handshake ready.
- `pix_out` out 16: raw pixel, zero-extended from bpp bits.
- `pix_transp` out 1: pixel comes from a transparent run; `pix_out` = 0.
- `pix_valid` out 1: output handshake valid.
- `pix_ready` in 1: output handshake ready.
- `row_done` out 1: one-cycle pulse when the row is complete.
- `busy` out 1: high from `row_start` acceptance until `row_done`.

## Operation

- States: IDLE, HDR, PKT, LIT, TRN, REP_LD, REP, UNPK, FLUSH, DONE.
- IDLE + `row_start`:
  - Reserved `bpp_code` → DONE directly; no words consumed.
  - Otherwise `packed` → HDR, else → UNPK.
- Bit buffer: `BUF_W` bits, consumed MSB-first.
  - Accepts a word (`word_ready`=1) whenever fill ≤ `BUF_W`−32 and the state still needs data.
  - Pixels may straddle word boundaries (6 bpp).
- Word counter `wcnt` (11 bits) counts accepted words in the row.
- UNPK:
  - Emits `row_width` pixels.
  - Then discards the remaining buffer bits (rows are word-aligned) → DONE.
- HDR:
  - Consumes the first word; `wlen` = word[9:0] + 2 = total row words including the header → PKT.
- PKT: pops an 8-bit header; type = [7:6], `n` = [5:0] + 1.
  - 00 → FLUSH (EOL).
  - 01 → LIT: emits `n` pixels from the stream.
  - 10 → TRN: emits `n` beats with `pix_out`=0, `pix_transp`=1; no bits consumed.
  - 11 → REP_LD pops one pixel, then REP emits it `n` times.
  - After each run → PKT.
- Word limit (packed):
  - When `wcnt` = `wlen`, no more words are accepted.
  - If a header or pixel then needs more bits than remain → FLUSH (row truncated; partial bits dropped).
- FLUSH:
  - Accepts and drops words until `wcnt` = `wlen` (packed only).
  - Clears the buffer → DONE.
- DONE: `row_done`=1 for one cycle → IDLE.
- Width rules:
  - `n` ≤ 64.
  - Run counter 7 bits; pixel counter 11 bits.
  - 16 bpp occupies all of `pix_out`.

## Timing

- Reset values: `word_ready`=0, `pix_valid`=0, `pix_out`=0, `pix_transp`=0, `row_done`=0, `busy`=0, state IDLE, buffer empty, counters 0.
- `areset` mid-row: everything returns to the reset values on the next edge, and any partial words are lost. The source must be re-aligned externally.
- `pix_out`/`pix_transp`/`pix_valid` are registered.
  - Once valid is asserted, they hold stable until `pix_valid && pix_ready`.
  - Sustained throughput is 1 pixel/cycle when words arrive fast enough.
- Latency: first `pix_valid` is 2 cycles after the first word is accepted in unpacked mode; 3 cycles in packed mode (header/packet decode).
- Words are accepted only on `word_valid && word_ready`. `word_ready` never depends on `pix_ready` combinationally.
- `row_done` follows the final pixel handshake by ≥ 1 cycle. `busy` drops in the same cycle as `row_done`.
- `row_start` in the same cycle as `row_done`: ignored (the block is not yet in IDLE).

## Test plan

- Unpacked 8 bpp, width 5, words 0x01020304, 0x05AABBCC → pixels 01,02,03,04,05 with `pix_transp`=0; `row_done`; exactly 2 words accepted.
- Unpacked 6 bpp, width 6, words 0x0420C414, 0x60000000 → pixels 1,2,3,4,5,6 (straddle at pixel 6); `row_done`.
- Packed 4 bpp, words 0x00000001, 0x42ABCC17, 0x80000000 → A,B,C,7,7 then one transparent beat (0, transp=1); `row_done`; 3 words consumed.
- Packed truncation, 4 bpp, words 0x00000000, 0x7F123456 → literal 64 requested, only 1,2,3,4,5,6 emitted; `row_done`; no third word accepted.
- Backpressure: scenario 1 with `pix_ready` toggling 1/0 each cycle → identical pixel order, each value held stable while stalled; `row_done` after the fifth handshake.
- Reserved `bpp_code`=7 → `row_done` 2 cycles after `row_start`; no word accepted. Also: `areset` during the third pixel of scenario 3 → all outputs 0 the next cycle, then IDLE.
